ibsm_vc: RTL and testbench
==========================

// Module: ibsm_vc
// PURPOSE
//  Input-buffer state machine for one switch input port, generalised to NVC virtual-channel FIFOs and NPORT outputs.
//  Round-robin picks a VC whose head flit is HEAD/HT, latches its route, requests the output arbiter and streams the packet out.
//  Also handles single-flit packets, FIFO bubbles mid-packet and stray non-head flits.
//  Sits between the per-VC input FIFOs plus route decoders (mkareq) and the output arbiters/crossbar.
// PARAMETERS
//  NPORT  4   switch output count = width of req and of each route vector
//  NVC    2   virtual channels (input FIFOs) per port, >=1
//  FLITW  36  flit width; flow-type field is bits [FLITW-1:FLITW-2]
//  CNTW   16  width of statistics counters (IBSM_STATS_EN only)
// PORTS
//  clk      in   1            clock
//  rst      in   1            reset, synchronous, active-high
//  empty    in   NVC          per-VC FIFO empty flag
//  pkto     in   NVC*FLITW    per-VC FIFO head flit, VC v at [v*FLITW +: FLITW]
//  reqi     in   NVC*NPORT    per-VC decoded route of head flit, VC v at [v*NPORT +: NPORT]
//  ack      in   1            arbiter grant for the current request
//  re       out  NVC          per-VC FIFO read enable (one-hot or zero)
//  req      out  NPORT        request vector to output arbiters
//  sel_vc   out  $clog2(NVC)  VC currently owned; crossbar muxes pkto with it (width 1 when NVC=1)
//  err      out  1            one-cycle pulse: stray non-head flit dropped
//  pkt_cnt  out  CNTW         packets forwarded (IBSM_STATS_EN)
//  drop_cnt out  CNTW         flits dropped (IBSM_STATS_EN)
// BEHAVIOUR
//  Reset: state IDLE, req=0, re=0, sel_vc=0, err=0, rr pointer=0, counters=0. Reset mid-packet abandons the packet.
//  Flow codes: HEAD, BODY, TAIL, HT (head+tail, single-flit packet).
//  IDLE: scan VCs from rr pointer upward, wrapping; take first v with empty[v]=0.
//   - head is HEAD or HT: latch sel_vc=v and route=reqi[v]; go REQ next cycle. req=0 and re=0 in IDLE.
//   - head is BODY/TAIL: re[v]=1, err=1 that cycle, stay IDLE (flit dropped).
//   - no non-empty VC: stay IDLE.
//  REQ: req=latched route (registered, valid from the cycle after the pick). ack=1: re[sel_vc]=1 same cycle (head popped);
//   next state XFER, or IDLE if the head was HT. ack=0: hold req, stay REQ.
//  XFER: req=latched route held for the whole packet. empty[sel_vc]=0: re[sel_vc]=1.
//   Popped flit TAIL: req=0 that cycle, next IDLE. empty=1 (bubble): re=0, req held, stay XFER. ack ignored in XFER.
//  rr pointer = sel_vc+1 mod NVC on packet completion (TAIL or HT popped), so no VC starves.
//  Latency: HEAD visible at t -> req at t+1. Earliest ack at t+1 -> head popped at t+1, body from t+2, one flit/cycle.
//  Stray flit in IDLE: dropped, never forwarded. Route of HEAD sampled once; later reqi changes ignored.
//  Single VC owned until TAIL; other VCs' HEADs wait (no interleave on one input).
// CONFIGURATION
//  IBSM_STATS_EN defined: pkt_cnt++ per TAIL/HT popped, drop_cnt++ per err pulse; both saturate at all-ones.
//  Undefined: no counter flops; pkt_cnt and drop_cnt driven constant 0. FSM behaviour identical either way.
// STRUCTURE
//  Shared package sw_pkg: flow-type codes, flow-field bit positions, state enum {IDLE,REQ,XFER}.
//  One sub-module: ibsm_rr_pick (NVC-wide rotate-priority picker: valid vector + pointer -> one-hot + index).
//  Remainder: FSM, route/sel_vc latch, rr pointer, optional counters.
// TESTING
//  Reset: rst=1 two cycles, VC0 holds HEAD -> req=0, re=0, err=0; after release req=route on 2nd cycle.
//  4-flit packet, NVC=2, VC0 HEAD route 4'b0100, ack at 3rd cycle -> re[0] 4 cycles; req=4'b0100 until TAIL pop, then 0.
//  HT flit on VC1, route 4'b0001, ack at once -> one re[1] pulse, back to IDLE; pkt_cnt=1 with STATS_EN.
//  Fairness: both VCs hold 2-flit packets, ack tied 1 -> VC0 packet, then VC1, then VC0; sel_vc alternates.
//  Bubble: empty[0]=1 two cycles mid-packet -> re=0, req held, no flit lost.
//  Stray: BODY at VC0 head in IDLE -> re[0]=1, err=1 one cycle, no req; drop_cnt=1 with STATS_EN.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared switch definitions: flit flow-type codes, flow-field layout and the
// input-buffer FSM state encoding.
package sw_pkg;

    localparam int FLOW_W = 2;

    typedef enum logic [1:0] {
        FLOW_BODY = 2'b00,
        FLOW_TAIL = 2'b01,
        FLOW_HEAD = 2'b10,
        FLOW_HT   = 2'b11
    } flow_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        XFER = 2'b10
    } state_e;

    // HEAD and HT both open a packet
    function automatic logic is_head(input logic [FLOW_W-1:0] flow);
        return (flow == FLOW_HEAD) || (flow == FLOW_HT);
    endfunction

endpackage

// File: rtl/ibsm_vc_if.sv
// Input-buffer bus: per-VC FIFO/route-decoder signals toward the FSM, and the
// read-enable/request/crossbar-select signals back out.
interface ibsm_vc_if #(
    parameter int NPORT = 4,
    parameter int NVC   = 2,
    parameter int FLITW = 36
);
    localparam int VCW = (NVC > 1) ? $clog2(NVC) : 1;

    logic [NVC-1:0]       empty;
    logic [NVC*FLITW-1:0] pkto;
    logic [NVC*NPORT-1:0] reqi;
    logic                 ack;
    logic [NVC-1:0]       re;
    logic [NPORT-1:0]     req;
    logic [VCW-1:0]       sel_vc;
    logic                 err;

    modport master (
        input  empty, pkto, reqi, ack,
        output re, req, sel_vc, err
    );

    modport slave (
        output empty, pkto, reqi, ack,
        input  re, req, sel_vc, err
    );

endinterface

// File: rtl/ibsm_rr_pick.sv
// Rotate-priority picker: first valid bit at or above ptr (wrapping), returned
// as one-hot vector plus binary index.
module ibsm_rr_pick #(
    parameter int NVC = 2,
    parameter int VCW = 1
) (
    input  logic [NVC-1:0] valid,
    input  logic [VCW-1:0] ptr,
    output logic [NVC-1:0] onehot,
    output logic [VCW-1:0] idx,
    output logic           any
);

    // scan NVC positions starting from ptr; first hit wins
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 0; i < NVC; i++) begin
            if (!any && valid[(int'(ptr) + i) % NVC]) begin
                any                             = 1'b1;
                idx                             = VCW'((int'(ptr) + i) % NVC);
                onehot[(int'(ptr) + i) % NVC]   = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/ibsm_vc.sv
// Input-buffer state machine for one switch input with NVC virtual channels.
// Optional statistics counters enabled by defining IBSM_STATS_EN.
module ibsm_vc
    import sw_pkg::*;
#(
    parameter int NPORT = 4,
    parameter int NVC   = 2,
    parameter int FLITW = 36,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    ibsm_vc_if.master       bus,
    output logic [CNTW-1:0] pkt_cnt,
    output logic [CNTW-1:0] drop_cnt
);

    localparam int VCW = (NVC > 1) ? $clog2(NVC) : 1;

    state_e           state_q, state_d;
    logic [VCW-1:0]   sel_q, sel_d;
    logic [VCW-1:0]   rr_q, rr_d;
    logic [NPORT-1:0] route_q, route_d;

    logic [NVC-1:0]    valid_s;
    logic [NVC-1:0]    pick_oh_s;
    logic [VCW-1:0]    pick_idx_s;
    logic              pick_any_s;
    logic [FLOW_W-1:0] pick_flow_s;
    logic [FLOW_W-1:0] own_flow_s;
    logic              own_empty_s;
    logic [NVC-1:0]    sel_oh_s;
    logic [NVC-1:0]    re_s;
    logic [NPORT-1:0]  req_s;
    logic              err_s;
    logic              done_s;

    assign valid_s = ~bus.empty;

    ibsm_rr_pick #(.NVC(NVC), .VCW(VCW)) u_pick (
        .valid  (valid_s),
        .ptr    (rr_q),
        .onehot (pick_oh_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    assign pick_flow_s = bus.pkto[int'(pick_idx_s)*FLITW + FLITW - FLOW_W +: FLOW_W];
    assign own_flow_s  = bus.pkto[int'(sel_q)*FLITW + FLITW - FLOW_W +: FLOW_W];
    assign own_empty_s = bus.empty[sel_q];

    // one-hot read enable for the owned VC
    always_comb begin
        sel_oh_s = '0;
        for (int v = 0; v < NVC; v++) begin
            sel_oh_s[v] = (int'(sel_q) == v);
        end
    end

    // next-state, latches and combinational handshake outputs
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        route_d = route_q;
        rr_d    = rr_q;
        re_s    = '0;
        req_s   = '0;
        err_s   = 1'b0;
        done_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    if (is_head(pick_flow_s)) begin
                        sel_d   = pick_idx_s;
                        route_d = bus.reqi[int'(pick_idx_s)*NPORT +: NPORT];
                        state_d = REQ;
                    end else begin
                        re_s  = pick_oh_s;
                        err_s = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                req_s = route_q;
                if (bus.ack && !own_empty_s) begin
                    re_s = sel_oh_s;
                    if (own_flow_s == FLOW_HT) begin
                        done_s  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = XFER;
                    end
                end else begin
                    state_d = REQ;
                end
            end
            XFER: begin
                // request stays up through bubbles; drops in the cycle the tail leaves
                if (!own_empty_s) begin
                    re_s = sel_oh_s;
                    if (own_flow_s == FLOW_TAIL) begin
                        done_s  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        req_s = route_q;
                    end
                end else begin
                    req_s = route_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (done_s) begin
            if (int'(sel_q) == NVC - 1) begin
                rr_d = '0;
            end else begin
                rr_d = sel_q + VCW'(1);
            end
        end else begin
            rr_d = rr_d;
        end
    end

    // FSM, owned VC, latched route and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            route_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            route_q <= route_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.re     = rst ? '0   : re_s;
    assign bus.req    = rst ? '0   : req_s;
    assign bus.err    = rst ? 1'b0 : err_s;
    assign bus.sel_vc = sel_q;

`ifdef IBSM_STATS_EN
    logic [CNTW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;

    // saturating packet/drop counters
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (done_s && !(&pkt_cnt_q)) begin
            pkt_cnt_d = pkt_cnt_q + CNTW'(1);
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
        if (err_s && !(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + CNTW'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    assign pkt_cnt  = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ibsm_vc.sv
// Directed bench for ibsm_vc: per-cycle expected re/req/err/sel_vc vectors
// plus an end-of-run check of the forwarded flit order.
module tb_ibsm_vc;
    import sw_pkg::*;

    localparam int NPORT = 4;
    localparam int NVC   = 2;
    localparam int FLITW = 36;
    localparam int CNTW  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ibsm_vc_if #(.NPORT(NPORT), .NVC(NVC), .FLITW(FLITW)) bus ();
    logic [CNTW-1:0] pkt_cnt;
    logic [CNTW-1:0] drop_cnt;

    ibsm_vc #(.NPORT(NPORT), .NVC(NVC), .FLITW(FLITW), .CNTW(CNTW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    logic [FLITW-1:0] fq [NVC][$];
    logic [FLITW-1:0] fwd[$];
    logic [FLITW-1:0] exp_fwd[$];
    logic [NPORT-1:0] rt [NVC];
    logic             hide0 = 1'b0;
    int               n_cmp = 0;
    int               n_bad = 0;
    int               nid   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [FLITW-1:0] mk(input logic [1:0] f, input int id);
        return {f, (FLITW-2)'(id)};
    endfunction

    // queue a flit on a VC; the caller lists the expected forwarding order separately
    task automatic push(input int v, input logic [1:0] f, output logic [FLITW-1:0] fl);
        nid++;
        fl = mk(f, nid);
        fq[v].push_back(fl);
    endtask

    task automatic drive();
        for (int v = 0; v < NVC; v++) begin
            bus.empty[v] = (fq[v].size() == 0) || (v == 0 && hide0);
            bus.pkto[v*FLITW +: FLITW] = (fq[v].size() != 0) ? fq[v][0] : '0;
            bus.reqi[v*NPORT +: NPORT] = rt[v];
        end
    endtask

    // called at negedge: capture pops, advance one clock, apply next inputs
    task automatic tick(input logic r_n, input logic a_n, input logic h_n);
        logic [NVC-1:0] re_c;
        re_c = bus.re;
        for (int v = 0; v < NVC; v++) begin
            if (re_c[v]) begin
                fwd.push_back(bus.pkto[v*FLITW +: FLITW]);
            end
        end
        @(posedge clk);
        #1;
        for (int v = 0; v < NVC; v++) begin
            if (re_c[v] && fq[v].size() != 0) begin
                void'(fq[v].pop_front());
            end
        end
        rst     = r_n;
        bus.ack = a_n;
        hide0   = h_n;
        drive();
        @(negedge clk);
    endtask

    task automatic cyc(input string tag, input logic r_n, input logic a_n, input logic h_n,
                       input logic [1:0] e_re, input logic [3:0] e_req, input logic e_err,
                       input int e_sel);
        chk({tag, ".re"},  64'(bus.re),  64'(e_re));
        chk({tag, ".req"}, 64'(bus.req), 64'(e_req));
        chk({tag, ".err"}, 64'(bus.err), 64'(e_err));
        if (e_sel >= 0) begin
            chk({tag, ".sel"}, 64'(bus.sel_vc), 64'(e_sel));
        end
        tick(r_n, a_n, h_n);
    endtask

    task automatic chk_cnt(input string tag, input int e_pkt, input int e_drop);
`ifdef IBSM_STATS_EN
        chk({tag, ".pkt"},  64'(pkt_cnt),  64'(e_pkt));
        chk({tag, ".drop"}, 64'(drop_cnt), 64'(e_drop));
`else
        chk({tag, ".pkt"},  64'(pkt_cnt),  64'(0));
        chk({tag, ".drop"}, 64'(drop_cnt), 64'(0));
`endif
    endtask

    initial begin
        logic [FLITW-1:0] f;
        logic [FLITW-1:0] p1h, p1t, p2h, p2t, qh, qt;
        bus.ack = 1'b0;
        rt[0] = 4'b0100;
        rt[1] = 4'b0001;
        // 4-flit packet on VC0, present during reset
        push(0, FLOW_HEAD, f); exp_fwd.push_back(f);
        push(0, FLOW_BODY, f); exp_fwd.push_back(f);
        push(0, FLOW_BODY, f); exp_fwd.push_back(f);
        push(0, FLOW_TAIL, f); exp_fwd.push_back(f);
        drive();
        @(negedge clk);
        cyc("rst0",     1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 0);
        cyc("rst1",     1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 0);
        cyc("pick",     1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 0);
        cyc("req1",     1'b0, 1'b0, 1'b0, 2'b00, 4'b0100, 1'b0, 0);
        cyc("req2",     1'b0, 1'b1, 1'b0, 2'b00, 4'b0100, 1'b0, 0);
        cyc("ackpop",   1'b0, 1'b0, 1'b0, 2'b01, 4'b0100, 1'b0, 0);
        cyc("body1",    1'b0, 1'b0, 1'b0, 2'b01, 4'b0100, 1'b0, 0);
        cyc("body2",    1'b0, 1'b0, 1'b0, 2'b01, 4'b0100, 1'b0, 0);
        cyc("tail",     1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b0, 0);
        chk_cnt("pkt4", 1, 0);
        // single-flit HT packet on VC1, ack held high
        push(1, FLOW_HT, f); exp_fwd.push_back(f);
        cyc("idle_a",   1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 0);
        cyc("ht_pick",  1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 0);
        cyc("ht_pop",   1'b0, 1'b1, 1'b0, 2'b10, 4'b0001, 1'b0, 1);
        chk_cnt("ht", 2, 0);
        // fairness: two 2-flit packets on VC0, one on VC1, rr pointer back at 0
        push(0, FLOW_HEAD, p1h); push(0, FLOW_TAIL, p1t);
        push(0, FLOW_HEAD, p2h); push(0, FLOW_TAIL, p2t);
        push(1, FLOW_HEAD, qh);  push(1, FLOW_TAIL, qt);
        exp_fwd.push_back(p1h); exp_fwd.push_back(p1t);
        exp_fwd.push_back(qh);  exp_fwd.push_back(qt);
        exp_fwd.push_back(p2h); exp_fwd.push_back(p2t);
        cyc("ht_done",  1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 1);
        cyc("f0_pick",  1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 1);
        cyc("f0_req",   1'b0, 1'b1, 1'b0, 2'b01, 4'b0100, 1'b0, 0);
        cyc("f0_tail",  1'b0, 1'b1, 1'b0, 2'b01, 4'b0000, 1'b0, 0);
        cyc("f1_pick",  1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 0);
        cyc("f1_req",   1'b0, 1'b1, 1'b0, 2'b10, 4'b0001, 1'b0, 1);
        cyc("f1_tail",  1'b0, 1'b1, 1'b0, 2'b10, 4'b0000, 1'b0, 1);
        cyc("f2_pick",  1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 1);
        cyc("f2_req",   1'b0, 1'b1, 1'b0, 2'b01, 4'b0100, 1'b0, 0);
        cyc("f2_tail",  1'b0, 1'b1, 1'b0, 2'b01, 4'b0000, 1'b0, 0);
        chk_cnt("fair", 5, 0);
        // 4-flit packet on VC0 with a two-cycle bubble after the first body flit
        push(0, FLOW_HEAD, f); exp_fwd.push_back(f);
        push(0, FLOW_BODY, f); exp_fwd.push_back(f);
        push(0, FLOW_BODY, f); exp_fwd.push_back(f);
        push(0, FLOW_TAIL, f); exp_fwd.push_back(f);
        cyc("f_idle",   1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 0);
        cyc("bub_pick", 1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 0);
        cyc("bub_req",  1'b0, 1'b1, 1'b0, 2'b01, 4'b0100, 1'b0, 0);
        cyc("bub_b1",   1'b0, 1'b1, 1'b1, 2'b01, 4'b0100, 1'b0, 0);
        cyc("bub_h1",   1'b0, 1'b1, 1'b1, 2'b00, 4'b0100, 1'b0, 0);
        cyc("bub_h2",   1'b0, 1'b1, 1'b0, 2'b00, 4'b0100, 1'b0, 0);
        cyc("bub_b2",   1'b0, 1'b1, 1'b0, 2'b01, 4'b0100, 1'b0, 0);
        cyc("bub_tail", 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b0, 0);
        // stray BODY flit at VC0 head while idle
        push(0, FLOW_BODY, f); exp_fwd.push_back(f);
        cyc("idle_b",   1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 0);
        cyc("stray",    1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b1, 0);
        cyc("post",     1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 0);
        chk_cnt("end", 6, 1);
        chk("fq0_empty", 64'(fq[0].size()), 64'(0));
        chk("fq1_empty", 64'(fq[1].size()), 64'(0));
        chk("fwd_len", 64'(fwd.size()), 64'(exp_fwd.size()));
        for (int i = 0; i < exp_fwd.size(); i++) begin
            if (i < fwd.size()) begin
                chk($sformatf("fwd[%0d]", i), 64'(fwd[i]), 64'(exp_fwd[i]));
            end else begin
                chk($sformatf("fwd[%0d].missing", i), 64'(1), 64'(0));
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
